life_grid_engine: RTL and testbench
===================================

LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 Parameter ROWS, default 8, number of grid rows (2..32).
REQ-002 Parameter COLS, default 8, number of grid columns (2..32).
REQ-003 Parameter RATE_DIV, default 1, clock cycles per generation in RUN (1..65535).
REQ-004 Port clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port on  input  1  run enable; 1 = evolve continuously, 0 = pause.
REQ-007 Port load  input  1  single-cycle pulse; re-seed grid from seed without reset.
REQ-008 Port step  input  1  single-cycle pulse; advance one generation while paused.
REQ-009 Port seed  input  ROWS*COLS  initial pattern; cell(r,c) = seed[ROWS*COLS-1-(r*COLS+c)], row 0 in MSBs.
REQ-010 Port display  output  ROWS*COLS  current generation, same bit mapping as seed.
REQ-011 Port generation  output  16  generation count since last load/reset, saturating at 16'hFFFF.
REQ-012 Port stable  output  1  last update produced a grid identical to its predecessor.
REQ-013 Port extinct  output  1  display is all zeros.
REQ-014 Port halted  output  1  FSM is in HALT.

Function
REQ-015 States SHALL be PAUSE, RUN, HALT; display SHALL be driven directly from the grid register.
REQ-016 PAUSE->RUN when on=1; RUN->PAUSE when on=0; RUN->HALT on the edge where an update sets stable or extinct; HALT exits only via reset or load.
REQ-017 Update rule: live cell with 2 or 3 live neighbours survives; dead cell with exactly 3 becomes live; all others dead; 8-neighbour Moore neighbourhood.
REQ-018 In RUN a divider SHALL count 0..RATE_DIV-1; the grid updates on the edge where the divider equals RATE_DIV-1, then wraps to 0; RATE_DIV=1 updates every cycle.
REQ-019 Divider SHALL hold its value in PAUSE and HALT and clear on load, reset, and entry to RUN.
REQ-020 In PAUSE a step pulse SHALL update the grid on the next edge (latency 1); step is ignored in RUN and HALT.
REQ-021 Each update SHALL increment generation by 1, saturating at 16'hFFFF without wrapping.
REQ-022 stable and extinct SHALL be registered and change only on update, load, or reset.
REQ-023 load SHALL copy seed into the grid, clear generation, stable, divider, set extinct = (seed==0), and go to PAUSE (on=0) or RUN (on=1), latency 1.
REQ-024 Priority: reset > load > update; a step or tick coincident with load SHALL be discarded.
REQ-025 seed changes without load or reset SHALL have no effect on display.

Reset
REQ-026 While reset=1 at an edge: grid <= seed, generation <= 0, stable <= 0, extinct <= (seed==0), divider <= 0, state <= PAUSE, halted <= 0.
REQ-027 Reset mid-update SHALL discard the update; on=1 after deassertion enters RUN on the next edge.

Configuration
REQ-028 Macro TORUS_WRAP_EN defined: neighbour indices wrap modulo ROWS and COLS (toroidal grid).
REQ-029 TORUS_WRAP_EN undefined: cells outside the grid count as dead (fixed dead border).

Verification
REQ-030 8x8, RATE_DIV=1, seed 64'h0000_0038_0000_0000, reset then on=1 -> display 64'h0000_1010_1000_0000 after 1 update, back to seed after 2; stable=0, generation=2.
REQ-031 8x8, seed 64'h0000_0018_1800_0000 (block), on=1 -> display unchanged, stable=1, halted=1 after first update, generation=1 thereafter.
REQ-032 8x8, seed 64'hC000_0000_0000_00C0, one update: TORUS_WRAP_EN defined -> display unchanged, stable=1; undefined -> display 0, extinct=1, halted=1.
REQ-033 RATE_DIV=4, blinker seed, on=1 for 12 cycles -> exactly 3 updates, each 4 cycles apart; drop on mid-count, raise again -> divider restarts from 0.
REQ-034 on=0, step pulses x3 with blinker -> generation=3, display vertical; step asserted with load same cycle -> grid=seed, generation=0.
REQ-035 Force generation to 16'hFFFE via 2 updates short of saturation path (RATE_DIV=1, oscillator, 65537 cycles) -> generation holds 16'hFFFF.

Source files
------------

// File: rtl/life_grid_engine.sv
// Conway's Game of Life engine: ROWS x COLS grid with PAUSE/RUN/HALT control and rate divider.
// Define TORUS_WRAP_EN for a toroidal grid; otherwise cells outside the grid count as dead.
module life_grid_engine #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int RATE_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on,
  input  logic                 load,
  input  logic                 step,
  input  logic [ROWS*COLS-1:0] seed,
  output logic [ROWS*COLS-1:0] display,
  output logic [15:0]          generation,
  output logic                 stable,
  output logic                 extinct,
  output logic                 halted
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [1:0] {PAUSE, RUN, HALT} state_t;

  state_t          state, state_next;
  logic [N-1:0]    grid, grid_nxt;
  logic [DW-1:0]   div, div_next;
  logic            upd;
  logic [3:0]      cnt;
  logic            alive;

  assign display = grid;

  // Cell lookup with row 0 / column 0 in the MSB; border handling chosen at build time.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
`ifdef TORUS_WRAP_EN
    int rr;
    int cc;
    rr = (r + ROWS) % ROWS;
    cc = (c + COLS) % COLS;
    return g[IW'(ROWS*COLS - 1 - (rr*COLS + cc))];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return g[IW'(ROWS*COLS - 1 - (r*COLS + c))];
`endif
  endfunction

  // Next generation from the Moore-neighbourhood live count.
  always_comb begin
    grid_nxt = '0;
    cnt      = '0;
    alive    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) cnt = cnt + 4'(cell_at(grid, r + dr, c + dc));
          end
        end
        alive = cell_at(grid, r, c);
        grid_nxt[IW'(ROWS*COLS - 1 - (r*COLS + c))] = (cnt == 4'd3) || (alive && cnt == 4'd2);
      end
    end
  end

  // Control: load overrides any step or divider tick in the same cycle.
  always_comb begin
    state_next = state;
    div_next   = div;
    upd        = 1'b0;
    case (state)
      PAUSE: begin
        upd = step;
        if (on) begin
          state_next = RUN;
          div_next   = '0;
        end
      end
      RUN: begin
        if (!on) begin
          state_next = PAUSE;
        end else if (div == DW'(RATE_DIV - 1)) begin
          upd      = 1'b1;
          div_next = '0;
          if (grid_nxt == grid || grid_nxt == '0) state_next = HALT;
        end else begin
          div_next = div + DW'(1);
        end
      end
      HALT:    state_next = HALT;
      default: state_next = PAUSE;
    endcase
    if (load) begin
      upd        = 1'b0;
      div_next   = '0;
      state_next = on ? RUN : PAUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= PAUSE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid       <= seed;
      generation <= '0;
      stable     <= 1'b0;
      extinct    <= (seed == '0);
      div        <= '0;
      halted     <= 1'b0;
    end else begin
      div    <= div_next;
      halted <= (state_next == HALT);
      if (load) begin
        grid       <= seed;
        generation <= '0;
        stable     <= 1'b0;
        extinct    <= (seed == '0);
      end else if (upd) begin
        grid       <= grid_nxt;
        generation <= (generation == 16'hFFFF) ? generation : generation + 16'd1;
        stable     <= (grid_nxt == grid);
        extinct    <= (grid_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed self-checking bench for life_grid_engine (RATE_DIV=1 and RATE_DIV=4 instances).
module tb_life_grid_engine;

  localparam logic [63:0] HORIZ  = 64'h0000_0038_0000_0000;
  localparam logic [63:0] VERT   = 64'h0000_1010_1000_0000;
  localparam logic [63:0] BLOCK  = 64'h0000_0018_1800_0000;
  localparam logic [63:0] CORNER = 64'hC000_0000_0000_00C0;

  logic        clk = 1'b0;
  logic        reset = 1'b0, on = 1'b0, load = 1'b0, step = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] display, d4_display;
  logic [15:0] generation, d4_generation;
  logic        stable, extinct, halted, d4_stable, d4_extinct, d4_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  life_grid_engine #(.ROWS(8), .COLS(8), .RATE_DIV(1)) dut (
    .clk(clk), .reset(reset), .on(on), .load(load), .step(step), .seed(seed),
    .display(display), .generation(generation), .stable(stable),
    .extinct(extinct), .halted(halted)
  );

  life_grid_engine #(.ROWS(8), .COLS(8), .RATE_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .on(on), .load(load), .step(step), .seed(seed),
    .display(d4_display), .generation(d4_generation), .stable(d4_stable),
    .extinct(d4_extinct), .halted(d4_halted)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [63:0] s);
    on    = 1'b0;
    load  = 1'b0;
    step  = 1'b0;
    seed  = s;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(HORIZ);
    n_checks++; if (display !== HORIZ) begin n_fail++; $display("FAIL reset_display got %h exp %h", display, HORIZ); end
    n_checks++; if (generation !== 16'd0) begin n_fail++; $display("FAIL reset_gen got %h exp 0", generation); end
    n_checks++; if ({stable, extinct, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {stable, extinct, halted}); end
    do_reset(64'd0);
    n_checks++; if (extinct !== 1'b1) begin n_fail++; $display("FAIL reset_extinct got %b exp 1", extinct); end
  endtask

  task automatic test_blinker_run();
    do_reset(HORIZ);
    on = 1'b1;
    tick();
    n_checks++; if (generation !== 16'd0 || display !== HORIZ) begin n_fail++; $display("FAIL run_entry got gen %h disp %h exp 0 %h", generation, display, HORIZ); end
    tick();
    n_checks++; if (display !== VERT) begin n_fail++; $display("FAIL blinker_gen1 got %h exp %h", display, VERT); end
    tick();
    n_checks++; if (display !== HORIZ) begin n_fail++; $display("FAIL blinker_gen2 got %h exp %h", display, HORIZ); end
    n_checks++; if (generation !== 16'd2) begin n_fail++; $display("FAIL blinker_count got %h exp 2", generation); end
    n_checks++; if ({stable, halted} !== 2'b00) begin n_fail++; $display("FAIL blinker_flags got %b exp 00", {stable, halted}); end
    on = 1'b0;
    tick();
  endtask

  task automatic test_block_halt();
    do_reset(BLOCK);
    on = 1'b1;
    tick();
    tick();
    n_checks++; if ({stable, halted} !== 2'b11) begin n_fail++; $display("FAIL block_halt got %b exp 11", {stable, halted}); end
    n_checks++; if (generation !== 16'd1) begin n_fail++; $display("FAIL block_gen got %h exp 1", generation); end
    repeat (3) tick();
    n_checks++; if (generation !== 16'd1 || display !== BLOCK) begin n_fail++; $display("FAIL block_hold got gen %h disp %h exp 1 %h", generation, display, BLOCK); end
    on = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++; if (generation !== 16'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_step_ignored got gen %h halted %b exp 1 1", generation, halted); end
  endtask

  task automatic test_load();
    seed = HORIZ;
    on   = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++; if ({halted, stable, extinct} !== 3'b000 || generation !== 16'd0 || display !== HORIZ) begin n_fail++; $display("FAIL load_from_halt got flags %b gen %h disp %h exp 000 0 %h", {halted, stable, extinct}, generation, display, HORIZ); end
    seed = BLOCK;
    repeat (2) tick();
    n_checks++; if (display !== HORIZ) begin n_fail++; $display("FAIL seed_no_effect got %h exp %h", display, HORIZ); end
    seed = 64'd0;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++; if (extinct !== 1'b1 || display !== 64'd0) begin n_fail++; $display("FAIL load_zero got ext %b disp %h exp 1 0", extinct, display); end
  endtask

  task automatic test_border();
    do_reset(CORNER);
    on = 1'b1;
    tick();
    tick();
`ifdef TORUS_WRAP_EN
    n_checks++; if (display !== CORNER) begin n_fail++; $display("FAIL torus_display got %h exp %h", display, CORNER); end
    n_checks++; if ({stable, extinct, halted} !== 3'b101) begin n_fail++; $display("FAIL torus_flags got %b exp 101", {stable, extinct, halted}); end
`else
    n_checks++; if (display !== 64'd0) begin n_fail++; $display("FAIL border_display got %h exp 0", display); end
    n_checks++; if ({stable, extinct, halted} !== 3'b011) begin n_fail++; $display("FAIL border_flags got %b exp 011", {stable, extinct, halted}); end
`endif
    on = 1'b0;
    tick();
  endtask

  task automatic test_step();
    do_reset(HORIZ);
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++; if (display !== VERT || generation !== 16'd1) begin n_fail++; $display("FAIL step1 got disp %h gen %h exp %h 1", display, generation, VERT); end
    tick();
    n_checks++; if (generation !== 16'd1) begin n_fail++; $display("FAIL step_idle got gen %h exp 1", generation); end
    for (int i = 0; i < 2; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    n_checks++; if (display !== VERT || generation !== 16'd3) begin n_fail++; $display("FAIL step3 got disp %h gen %h exp %h 3", display, generation, VERT); end
    step = 1'b1;
    load = 1'b1;
    seed = HORIZ;
    tick();
    step = 1'b0;
    load = 1'b0;
    n_checks++; if (display !== HORIZ || generation !== 16'd0) begin n_fail++; $display("FAIL step_with_load got disp %h gen %h exp %h 0", display, generation, HORIZ); end
  endtask

  task automatic test_rate_div();
    logic [15:0] exp_gen;
    do_reset(HORIZ);
    on = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_gen = 16'(k / 4);
      n_checks++; if (d4_generation !== exp_gen) begin n_fail++; $display("FAIL div4_cycle%0d got %h exp %h", k, d4_generation, exp_gen); end
    end
    repeat (2) tick();
    on = 1'b0;
    tick();
    on = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_gen = (k == 4) ? 16'd4 : 16'd3;
      n_checks++; if (d4_generation !== exp_gen) begin n_fail++; $display("FAIL div4_restart%0d got %h exp %h", k, d4_generation, exp_gen); end
    end
    on = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset(HORIZ);
    on = 1'b1;
    tick();
    repeat (65534) tick();
    n_checks++; if (generation !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got %h exp fffe", generation); end
    tick();
    n_checks++; if (generation !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got %h exp ffff", generation); end
    repeat (2) tick();
    n_checks++; if (generation !== 16'hFFFF || halted !== 1'b0) begin n_fail++; $display("FAIL sat_hold got gen %h halted %b exp ffff 0", generation, halted); end
    on = 1'b0;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_blinker_run();
    test_block_halt();
    test_load();
    test_border();
    test_step();
    test_rate_div();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
